// File: rtl/rambus_pkg.sv
// rtl/rambus_pkg.sv - shared types and widths for the rambus Wishbone master
package rambus_pkg;

    localparam int RAM_WORD_AW = 8;
    localparam int DATA_W      = 32;
    localparam int SEL_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rambus_rst_sync.sv
// rtl/rambus_rst_sync.sv - 2-flop reset synchroniser, async assert / sync deassert
module rambus_rst_sync (
    input  logic clk,
    input  logic rst_n,
    output logic rst_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], 1'b0};
        end
    end

    assign rst_o = sync_q[1];

endmodule

// File: rtl/rambus_wb_master.sv
// rtl/rambus_wb_master.sv - single-request Wishbone classic master for the rambus RAM
// Optional ack timeout enabled by RAMBUS_TIMEOUT_EN.
module rambus_wb_master
    import rambus_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [SEL_W-1:0]       req_sel_i,
    input  logic [RAM_WORD_AW-1:0] req_adr_i,
    input  logic [DATA_W-1:0]      req_dat_i,
    output logic                   rsp_valid_o,
    output logic [DATA_W-1:0]      rsp_dat_o,
    output logic                   rsp_err_o,
    output logic                   rambus_wb_clk_o,
    output logic                   rambus_wb_rst_o,
    output logic                   rambus_wb_cyc_o,
    output logic                   rambus_wb_stb_o,
    output logic                   rambus_wb_we_o,
    output logic [SEL_W-1:0]       rambus_wb_sel_o,
    output logic [DATA_W-1:0]      rambus_wb_dat_o,
    output logic [ADDR_WIDTH-1:0]  rambus_wb_adr_o,
    input  logic                   rambus_wb_ack_i,
    input  logic [DATA_W-1:0]      rambus_wb_dat_i
);

    state_t state_q, state_d;

    logic                  we_q;
    logic [SEL_W-1:0]      sel_q;
    logic [DATA_W-1:0]     dat_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_W-1:0]     rsp_dat_q;
    logic                  accept;
    logic                  bus_ack;
    logic                  bus_tmo;

    assign accept  = (state_q == IDLE) && req_valid_i;
    assign bus_ack = (state_q == BUS) && rambus_wb_ack_i;

`ifdef RAMBUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             rsp_err_q;

    // Ack in the last allowed cycle still wins over the timeout.
    assign bus_tmo = (state_q == BUS) && !rambus_wb_ack_i && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == BUS) ? cnt_q + 1'b1 : '0;
            if (bus_ack) begin
                rsp_err_q <= 1'b0;
            end else if (bus_tmo) begin
                rsp_err_q <= 1'b1;
            end
        end
    end

    assign rsp_err_o = rsp_err_q;
`else
    assign bus_tmo   = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = BUS;
            BUS:     if (bus_ack || bus_tmo) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            we_q      <= 1'b0;
            sel_q     <= '0;
            dat_q     <= '0;
            adr_q     <= '0;
            rsp_dat_q <= '0;
        end else begin
            if (accept) begin
                we_q  <= req_we_i;
                sel_q <= req_sel_i;
                dat_q <= req_dat_i;
                adr_q <= ADDR_WIDTH'({req_adr_i, 2'b00});
            end
            if (bus_ack) begin
                rsp_dat_q <= we_q ? '0 : rambus_wb_dat_i;
            end else if (bus_tmo) begin
                rsp_dat_q <= '0;
            end
        end
    end

    rambus_rst_sync u_rst_sync (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .rst_o (rambus_wb_rst_o)
    );

    assign req_ready_o     = (state_q == IDLE);
    assign rsp_valid_o     = (state_q == RESP);
    assign rsp_dat_o       = rsp_dat_q;
    assign rambus_wb_clk_o = wb_clk_i;
    assign rambus_wb_cyc_o = (state_q == BUS);
    assign rambus_wb_stb_o = (state_q == BUS);
    assign rambus_wb_we_o  = we_q;
    assign rambus_wb_sel_o = sel_q;
    assign rambus_wb_dat_o = dat_q;
    assign rambus_wb_adr_o = adr_q;

endmodule

// File: tb/tb_rambus_wb_master.sv
// tb/tb_rambus_wb_master.sv - scoreboard bench for rambus_wb_master
module tb_rambus_wb_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_sel;
    logic [7:0]  req_adr;
    logic [31:0] req_dat;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        bus_clk;
    logic        bus_rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_o;
    logic [9:0]  adr;
    logic        ack;
    logic [31:0] dat_i;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [32:0] exp_q[$];

    rambus_wb_master #(.ADDR_WIDTH(10), .TIMEOUT(16)) dut (
        .wb_clk_i        (clk),
        .wb_rst_ni       (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_we_i        (req_we),
        .req_sel_i       (req_sel),
        .req_adr_i       (req_adr),
        .req_dat_i       (req_dat),
        .rsp_valid_o     (rsp_valid),
        .rsp_dat_o       (rsp_dat),
        .rsp_err_o       (rsp_err),
        .rambus_wb_clk_o (bus_clk),
        .rambus_wb_rst_o (bus_rst),
        .rambus_wb_cyc_o (cyc),
        .rambus_wb_stb_o (stb),
        .rambus_wb_we_o  (we),
        .rambus_wb_sel_o (sel),
        .rambus_wb_dat_o (dat_o),
        .rambus_wb_adr_o (adr),
        .rambus_wb_ack_i (ack),
        .rambus_wb_dat_i (dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Response monitor: every completion pulse must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_rsp: got dat 0x%08h err %0b expected no response at %0t",
                             rsp_dat, rsp_err, $time);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("rsp_dat", rsp_dat, e[31:0]);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [3:0] s, input logic [7:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rdat,
                         input logic exp_err, input logic keep_valid);
        int n;
        req_we = w; req_sel = s; req_adr = a; req_dat = d; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) chk("accept_timeout", 32'(n), 32'd0);
        exp_q.push_back({exp_err, exp_rdat});
        @(negedge clk);
        chk("cyc_after_accept", {31'd0, cyc}, 32'd1);
        chk("ready_in_bus", {31'd0, req_ready}, 32'd0);
        if (!keep_valid) req_valid = 1'b0;
    endtask

    task automatic respond(input logic w, input logic [3:0] s, input logic [9:0] a,
                           input logic [31:0] d, input int delay, input logic [31:0] rdata);
        int n;
        logic ok;
        n = 0;
        @(negedge clk);
        while (!cyc && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) chk("bus_start_timeout", 32'(n), 32'd0);
        chk("adr_o", {22'd0, adr}, {22'd0, a});
        chk("we_o", {31'd0, we}, {31'd0, w});
        chk("sel_o", {28'd0, sel}, {28'd0, s});
        chk("stb_o", {31'd0, stb}, 32'd1);
        if (w) chk("dat_o", dat_o, d);
        ok = 1'b1;
        repeat (delay) begin
            @(negedge clk);
            if (!(cyc && stb && adr == a && we == w && sel == s && (!w || dat_o == d))) ok = 1'b0;
        end
        chk("bus_stable", {31'd0, ok}, 32'd1);
        ack = 1'b1; dat_i = rdata;
        @(negedge clk);
        ack = 1'b0; dat_i = 32'h0BAD_F00D;
        chk("cyc_drop_after_ack", {31'd0, cyc}, 32'd0);
        chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
        chk("rsp_valid_at_k+1", {31'd0, rsp_valid}, 32'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_sel = 4'h0;
        req_adr = 8'h00; req_dat = 32'h0; ack = 1'b0; dat_i = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", {31'd0, cyc}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_bus_rst", {31'd0, bus_rst}, 32'd1);
        chk("rst_adr", {22'd0, adr}, 32'd0);
        chk("rst_rsp_dat", rsp_dat, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);

        fork
            issue(1'b1, 4'hF, 8'h05, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
            respond(1'b1, 4'hF, 10'h014, 32'hDEADBEEF, 1, 32'h0);
        join
        @(negedge clk);

        fork
            issue(1'b0, 4'hF, 8'h05, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
            respond(1'b0, 4'hF, 10'h014, 32'h0, 0, 32'hDEADBEEF);
        join
        @(negedge clk);
        chk("rsp_valid_one_cycle", {31'd0, rsp_valid}, 32'd0);
        chk("rsp_dat_hold", rsp_dat, 32'hDEADBEEF);

        fork
            issue(1'b0, 4'h3, 8'hFF, 32'h0, 32'h12345678, 1'b0, 1'b0);
            respond(1'b0, 4'h3, 10'h3FC, 32'h0, 7, 32'h12345678);
        join
        @(negedge clk);

        fork
            issue(1'b1, 4'h0, 8'h80, 32'hA5A5_5A5A, 32'h0, 1'b0, 1'b0);
            respond(1'b1, 4'h0, 10'h200, 32'hA5A5_5A5A, 2, 32'hFFFF_FFFF);
        join
        @(negedge clk);

        // Four back-to-back requests with req_valid held high throughout.
        fork
            issue(1'b1, 4'h1, 8'h10, 32'h1111_1111, 32'h0, 1'b0, 1'b1);
            respond(1'b1, 4'h1, 10'h040, 32'h1111_1111, 0, 32'h0);
        join
        fork
            issue(1'b0, 4'h2, 8'h11, 32'h0, 32'h2222_2222, 1'b0, 1'b1);
            respond(1'b0, 4'h2, 10'h044, 32'h0, 1, 32'h2222_2222);
        join
        fork
            issue(1'b1, 4'h4, 8'h12, 32'h3333_3333, 32'h0, 1'b0, 1'b1);
            respond(1'b1, 4'h4, 10'h048, 32'h3333_3333, 0, 32'h0);
        join
        fork
            issue(1'b0, 4'h8, 8'h13, 32'h0, 32'h4444_4444, 1'b0, 1'b0);
            respond(1'b0, 4'h8, 10'h04C, 32'h0, 3, 32'h4444_4444);
        join
        repeat (2) @(negedge clk);

        ack = 1'b1; dat_i = 32'hCAFE_0000;
        repeat (2) @(negedge clk);
        chk("idle_ack_ignored_cyc", {31'd0, cyc}, 32'd0);
        ack = 1'b0;
        repeat (2) @(negedge clk);

`ifdef RAMBUS_TIMEOUT_EN
        fork
            issue(1'b0, 4'hF, 8'h20, 32'h0, 32'h0, 1'b1, 1'b0);
            begin
                n = 0;
                @(negedge clk);
                while (cyc && n < 100) begin @(negedge clk); n++; end
                chk("timeout_cycles", 32'(n), 32'd16);
            end
        join
        ack = 1'b1; dat_i = 32'h5555_5555;
        @(negedge clk);
        ack = 1'b0;
        repeat (3) @(negedge clk);
`endif

        req_we = 1'b0; req_sel = 4'hF; req_adr = 8'h33; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_bus_cyc", {31'd0, cyc}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cyc", {31'd0, cyc}, 32'd0);
        chk("async_rst_adr", {22'd0, adr}, 32'd0);
        chk("async_rst_sel", {28'd0, sel}, 32'd0);
        chk("async_rst_bus_rst", {31'd0, bus_rst}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("bus_rst_edge1", {31'd0, bus_rst}, 32'd1);
        @(posedge clk); #1;
        chk("bus_rst_edge2", {31'd0, bus_rst}, 32'd0);
        repeat (4) @(negedge clk);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rambus_wb_master.md
RAMBUS_WB_MASTER -- requirements
Module: rambus_wb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: rambus byte-address width SHALL be ADDR_WIDTH.
REQ-002 Parameter TIMEOUT, default 16: the ack-wait limit in cycles SHALL be TIMEOUT (used only with RAMBUS_TIMEOUT_EN).
REQ-003 wb_clk_i  in  1  SHALL be the single clock for all state.
REQ-004 wb_rst_ni  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid_i  in  1  SHALL indicate that the user request is valid.
REQ-006 req_ready_o  out  1  SHALL indicate that the block accepts a request.
REQ-007 req_we_i  in  1  SHALL select write when 1 and read when 0.
REQ-008 req_sel_i  in  4  SHALL carry the byte lane select.
REQ-009 req_adr_i  in  8  SHALL carry the RAM word address.
REQ-010 req_dat_i  in  32  SHALL carry the write data.
REQ-011 rsp_valid_o  out  1  SHALL be a one-cycle completion pulse.
REQ-012 rsp_dat_o  out  32  SHALL carry the read data.
REQ-013 rsp_err_o  out  1  SHALL flag completion by timeout.
REQ-014 rambus_wb_clk_o  out  1  SHALL be the bus clock, equal to wb_clk_i.
REQ-015 rambus_wb_rst_o  out  1  SHALL be the active-high bus reset.
REQ-016 rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o  out  1 each  SHALL be the Wishbone classic controls.
REQ-017 rambus_wb_sel_o  out  4;  rambus_wb_dat_o  out  32;  rambus_wb_adr_o  out  ADDR_WIDTH  SHALL carry the bus select, write data and byte address.
REQ-018 rambus_wb_ack_i  in  1;  rambus_wb_dat_i  in  32  SHALL carry the responder ack and read data.

Function
REQ-019 The FSM SHALL have three states: IDLE, BUS and RESP.
REQ-020 req_ready_o SHALL be 1 only in IDLE; a request SHALL be accepted on req_valid_i & req_ready_o, its fields SHALL be latched, and the state SHALL move to BUS.
REQ-021 In BUS, cyc_o and stb_o SHALL be 1 and we/sel/dat/adr SHALL hold the latched values, stable until ack_i is sampled high.
REQ-022 rambus_wb_adr_o SHALL be {req_adr, 2'b00}, zero-extended to ADDR_WIDTH.
REQ-023 On ack_i in BUS: cyc_o/stb_o SHALL be 0 from the next cycle, rambus_wb_dat_i SHALL be captured on a read, rsp_dat_o SHALL be 0 on a write, and the state SHALL move to RESP.
REQ-024 RESP SHALL assert rsp_valid_o for exactly one cycle and then return to IDLE; there SHALL be no response backpressure.
REQ-025 Latency: accept in cycle 0, cyc_o high in cycle 1, ack in cycle k >= 1, rsp_valid_o in cycle k+1; throughput SHALL be at most one transaction per 3 cycles.
REQ-026 ack_i outside BUS SHALL be ignored; req_valid_i outside IDLE SHALL be ignored and not queued.
REQ-027 A request with req_sel_i = 0 SHALL still run a full bus cycle with sel_o = 0.
REQ-028 rsp_dat_o and rsp_err_o SHALL hold their values until the next RESP.

Reset
REQ-029 Asserting wb_rst_ni SHALL force IDLE and clear cyc/stb/we/rsp_valid/rsp_err to 0 and sel/dat/adr/rsp_dat to 0 immediately, including mid-transaction, with no response produced.
REQ-030 rambus_wb_rst_o SHALL assert asynchronously with wb_rst_ni and deassert on the second wb_clk_i edge after release.

Configuration
REQ-031 With RAMBUS_TIMEOUT_EN defined: a BUS counter SHALL run, and if TIMEOUT cycles pass without ack, cyc/stb SHALL drop, RESP SHALL be entered with rsp_err_o=1 and rsp_dat_o=0, and a late ack SHALL be ignored.
REQ-032 Without RAMBUS_TIMEOUT_EN: BUS SHALL wait indefinitely, rsp_err_o SHALL be constant 0, and no counter SHALL be present.

Structure
REQ-033 Package rambus_pkg SHALL hold the state enum, RAM_WORD_AW=8, DATA_W=32 and SEL_W=4.
REQ-034 Sub-module rambus_rst_sync (2-flop async-assert, sync-deassert) SHALL generate rambus_wb_rst_o.

Verification
REQ-035 Write adr 0x05, dat 0xDEADBEEF, sel 0xF, ack in cycle 2 -> adr_o=0x014, we_o=1, rsp_valid_o in cycle 3, rsp_err_o=0.
REQ-036 Read adr 0x05, responder returns 0xDEADBEEF -> rsp_dat_o=0xDEADBEEF, cyc_o low the cycle after ack.
REQ-037 Read adr 0xFF with ack delayed 7 cycles -> bus signals stable throughout, adr_o=0x3FC, rsp_valid_o exactly one cycle.
REQ-038 req_valid_i held high for 4 back-to-back requests -> req_ready_o low in BUS/RESP, 4 bus cycles, no request lost.
REQ-039 RAMBUS_TIMEOUT_EN with TIMEOUT=16 and ack never asserted -> cyc_o drops after 16 cycles, rsp_err_o=1, rsp_dat_o=0; a late ack is ignored.
REQ-040 wb_rst_ni low mid-BUS -> cyc_o=0 asynchronously, no rsp_valid_o, rambus_wb_rst_o deasserts 2 edges after release.
